// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial subtractor state encoding and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Bit counter width for an arbitrary operand width; counts 0 .. w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, bout is the borrow out.
// Purely combinational, zero latency, no backpressure.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through a single full-subtractor cell.
// Latency WIDTH+1 cycles from accepted start to the done pulse.
// No backpressure: start is only accepted in IDLE/DONE and ignored while busy.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             msb_bin;
    logic             d_bit;
    logic             b_next;
    logic [WIDTH-1:0] r_next;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (b_next)
    );

    assign r_next = {d_bit, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            msb_bin  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r_sr <= r_next;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= b_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // br here is the borrow feeding the MSB cell
                        msb_bin  <= br;
                        diff     <= r_next;
                        bout     <= b_next;
                        overflow <= br ^ b_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an integer arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int ux, uy, sx, sy, uf, sf;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        uf = ux - uy - int'(c);
        sf = sx - sy - int'(c);
        d  = W'(uf & 255);
        bo = (uf < 0);
        ov = (sf < -128) || (sf > 127);
    endfunction

    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; bin = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (done) break;
            if (cycles > 30) begin
                total++; bad++;
                $display("FAIL wait_done: no done within %0d cycles", cycles);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, diff, bout, overflow} !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        int busy_cnt = 0;
        int done_at  = -1;
        int ndone    = 0;
        do_start(8'h35, 8'h12, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
                total++;
                if (diff !== 8'h23 || bout !== 1'b0 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_result: diff=%h bout=%b ovf=%b, want 23 0 0", diff, bout, overflow);
                end
            end
        end
        total++;
        if (done_at !== 9 || ndone !== 1) begin
            bad++;
            $display("FAIL done_latency: done at cycle %0d count %0d, want cycle 9 count 1", done_at, ndone);
        end
        total++;
        if (busy_cnt !== 8) begin
            bad++;
            $display("FAIL busy_length: %0d cycles, want 8", busy_cnt);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h00, 8'h80, 8'h10, 8'h7F};
        logic [W-1:0] vb [4] = '{8'h01, 8'h01, 8'h0F, 8'hFF};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] ed [4] = '{8'hFF, 8'h7F, 8'h00, 8'h80};
        logic         eb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic         eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            do_start(va[i], vb[i], vc[i]);
            wait_done(cyc);
            total++;
            if (diff !== ed[i] || bout !== eb[i] || overflow !== eo[i]) begin
                bad++;
                $display("FAIL directed_%0d: diff=%h bout=%b ovf=%b, want %h %b %b",
                         i, diff, bout, overflow, ed[i], eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] prev;
        int ndone = 0;
        int held_bad = 0;
        prev = 8'h80;
        do_start(8'h44, 8'h11, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a = 8'h99; b = 8'h99; bin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                total++;
                if (diff !== 8'h33 || bout !== 1'b0 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL ignore_result: diff=%h bout=%b ovf=%b, want 33 0 0", diff, bout, overflow);
                end
            end else if (ndone == 0 && diff !== prev) begin
                held_bad++;
            end
        end
        start = 1'b0;
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL ignore_done_count: %0d pulses, want 1", ndone);
        end
        total++;
        if (held_bad !== 0) begin
            bad++;
            $display("FAIL diff_held: %0d cycles with diff changed during run, want 0", held_bad);
        end
    endtask

    task automatic test_back_to_back();
        int when [2];
        logic [W-1:0] rd [2];
        logic rb [2];
        int n = 0;
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 25 && n < 2; i++) begin
            @(negedge clk);
            a = 8'h03; b = 8'h05;
            if (done) begin
                when[n] = i; rd[n] = diff; rb[n] = bout;
                n++;
                if (n == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL b2b_count: %0d pulses, want 2", n);
        end else begin
            total++;
            if (when[1] - when[0] !== 9) begin
                bad++;
                $display("FAIL b2b_spacing: %0d cycles, want 9", when[1] - when[0]);
            end
            total++;
            if (rd[0] !== 8'h02 || rb[0] !== 1'b0 || rd[1] !== 8'hFE || rb[1] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_results: %h/%b %h/%b, want 02/0 fe/1", rd[0], rb[0], rd[1], rb[1]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int cyc;
        do_start(8'hA5, 8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        total++;
        if ({busy, done, diff, bout, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, overflow);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++;
            $display("FAIL reset_mid_activity: %0d active cycles after reset, want 0", ndone);
        end
        do_start(8'hC8, 8'h64, 1'b0);
        wait_done(cyc);
        total++;
        if (diff !== 8'h64 || bout !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: diff=%h bout=%b ovf=%b, want 64 0 1", diff, bout, overflow);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, ed;
        logic c, eb, eo;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom_range(0, 255));
            y = W'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            model(x, y, c, ed, eb, eo);
            do_start(x, y, c);
            wait_done(cyc);
            total++;
            if (diff !== ed || bout !== eb || overflow !== eo || cyc !== 9) begin
                bad++;
                $display("FAIL random_%0d: %h-%h-%b got %h/%b/%b in %0d cyc, want %h/%b/%b in 9",
                         i, x, y, c, diff, bout, overflow, cyc, ed, eb, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b - bin` one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow. It is the subtract-direction counterpart to the datapath's full-adder cell, for area-constrained arithmetic where latency is acceptable. It is controlled by a start/done handshake and sits between an operand-issuing controller and a result consumer.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits, must be ≥ 2.

Ports:
- `clk`, input, 1: single clock, rising-edge active.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new subtraction. Sampled only in IDLE or DONE.
- `a`, input, WIDTH: minuend, captured on the accepted `start` edge.
- `b`, input, WIDTH: subtrahend, captured on the accepted `start` edge.
- `bin`, input, 1: borrow-in, captured on the accepted `start` edge.
- `busy`, output, 1: high while bits are being processed (RUN).
- `done`, output, 1: one-cycle pulse marking a valid new result.
- `diff`, output, WIDTH: registered difference, held until the next completion.
- `bout`, output, 1: borrow out of the MSB (unsigned `a < b + bin`).
- `overflow`, output, 1: signed overflow, defined as borrow into MSB XOR borrow out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1: capture `a`, `b` into shift registers, load borrow register with `bin`, clear bit counter, go to RUN. If `start`=0, stay in IDLE.
- RUN, each edge:
  - Full-subtractor inputs are `a_sr[0]`, `b_sr[0]` and the borrow register.
  - Difference bit shifts into the MSB of the result shift register.
  - Operand registers shift right; borrow register takes the new borrow; counter increments.
  - On the edge processing bit WIDTH-1: record the MSB borrow-in for overflow, then go to DONE.
- Entering DONE: `diff` is loaded from the result shift register, `bout` from the final borrow, `overflow` from the MSB borrow-in XOR the final borrow.
- DONE lasts one cycle with `done`=1.
  - `start`=1 in DONE behaves exactly as in IDLE and goes straight to RUN (back-to-back).
  - Otherwise go to IDLE.
- `start` in RUN is ignored; operands are not re-captured.
- Cell equations: `d = x ^ y ^ br`; `bo = (~x & y) | (~(x ^ y) & br)`.
- Arithmetic is modulo 2^WIDTH. No operand is sign-extended.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `overflow`=0, state IDLE. Internal shift registers, counter and borrow are also 0.
- Latency: with `start` accepted at edge k, `busy`=1 during cycles k+1 … k+WIDTH. `done`=1 and the new `diff`/`bout`/`overflow` are visible in cycle k+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- `diff`, `bout` and `overflow` change only on the edge entering DONE. They hold the previous result during RUN.
- Reset mid-operation: the in-flight result is discarded, all outputs return to reset values, and `done` does not pulse.
- `rst` and `start` asserted in the same cycle: reset wins.

## Structure
- Shared package `arith_pkg`: state enum `sub_state_t` (IDLE, RUN, DONE) and a helper constant `CNT_W = $clog2(WIDTH)`.
- One sub-module: `full_subtractor`, a combinational 1-bit cell with ports `x`, `y`, `bin`, `d`, `bout`, instantiated once.
- Top level holds the FSM, the three shift registers, the counter and the borrow register.

## Test plan
All scenarios use WIDTH=8.
- 0x35 - 0x12, `bin`=0 → `diff`=0x23, `bout`=0, `overflow`=0. `done` pulses exactly 9 cycles after the start edge, and `busy` is high for 8 cycles.
- 0x00 - 0x01, `bin`=0 → `diff`=0xFF, `bout`=1, `overflow`=0. Then 0x80 - 0x01 → `diff`=0x7F, `bout`=0, `overflow`=1.
- 0x10 - 0x0F, `bin`=1 → `diff`=0x00, `bout`=0, `overflow`=0. Then 0x7F - 0xFF, `bin`=0 → `diff`=0x80, `bout`=1, `overflow`=1.
- Start 0x44 - 0x11, then pulse `start` with 0x99 - 0x99 at RUN cycle 3 → result 0x33, no second `done`, and `diff` holds its prior value until completion.
- Back-to-back: `start` held high with 0x05 - 0x03 then 0x03 - 0x05 → two `done` pulses 9 cycles apart, results 0x02 (`bout`=0) then 0xFE (`bout`=1).
- Assert `rst` at RUN cycle 4 → all outputs 0 next cycle, no `done`. A new start after reset produces a correct result.
